// File: rtl/ozphy_polling_ctrl.sv
// Per-lane Detect/Polling link-training controller with PIPE-style status outputs.
// Each lane trains independently through TS1/TS2 exchange; link_up reports all lanes in L0.
//
// state          | meaning
// DETECT_QUIET   | idle, waiting for a receiver-detect request
// DETECT_ACTIVE  | detect acknowledged, waiting for P0 power state
// POLLING_WAIT   | electrical idle for QUIET_CYC cycles
// POLLING_ACTIVE | transmitting TS1 sets, counting received TS1/TS2
// POLLING_CONFIG | transmitting TS2 sets, counting received TS2
// L0             | trained, idle data until reset
module ozphy_polling_ctrl #(
    parameter int N_LANES   = 16,
    parameter int NTS       = 1024,
    parameter int QUIET_CYC = 4,
    parameter int TIMEOUT   = 24000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_LANES-1:0]     txdetectrx,
    input  logic [3*N_LANES-1:0]   powerdown,
    input  logic [N_LANES-1:0]     rx_ts1_det,
    input  logic [N_LANES-1:0]     rx_ts2_det,
    output logic [N_LANES-1:0]     phystatus,
    output logic [3*N_LANES-1:0]   rxstatus,
    output logic [8*N_LANES-1:0]   tx_data,
    output logic [N_LANES-1:0]     tx_datak,
    output logic [N_LANES-1:0]     tx_elecidle,
    output logic [3*N_LANES-1:0]   lane_state,
    output logic                   link_up
);

    typedef enum logic [2:0] {
        DETECT_QUIET   = 3'd0,
        DETECT_ACTIVE  = 3'd1,
        POLLING_WAIT   = 3'd2,
        POLLING_ACTIVE = 3'd3,
        POLLING_CONFIG = 3'd4,
        L0             = 3'd5
    } lane_state_e;

    // The set counter must reach both NTS (TS1 phase) and 16 (TS2 phase).
    localparam int TX_MAX = (NTS > 16) ? NTS : 16;
    localparam int TXW    = $clog2(TX_MAX + 1);
    localparam int TMW    = $clog2(TIMEOUT + 1);
    localparam int QW     = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;

    localparam logic [TXW-1:0] TX_SAT    = TXW'(TX_MAX);
    localparam logic [TXW-1:0] TS1_LAST  = TXW'(NTS - 1);
    localparam logic [TXW-1:0] TS2_LAST  = TXW'(15);
    localparam logic [TMW-1:0] TMR_LOAD  = TMW'(TIMEOUT - 1);
    localparam logic [QW-1:0]  WAIT_LOAD = QW'(QUIET_CYC - 1);
    localparam logic [3:0]     RX_SAT    = 4'd8;

    // Returns {datak, data} for one symbol of a TS1 or TS2 ordered set.
    function automatic logic [8:0] ts_symbol(input logic [3:0] idx, input logic ts2);
        logic [8:0] s;
        case (idx)
            4'd0:       s = 9'h1BC;
            4'd1, 4'd2: s = 9'h1F7;
            4'd3, 4'd5: s = 9'h000;
            4'd4:       s = 9'h002;
            default:    s = ts2 ? 9'h045 : 9'h04A;
        endcase
        return s;
    endfunction

    logic [N_LANES-1:0] in_l0;

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        lane_state_e    st_q;
        logic [3:0]     idx_q;
        logic [TXW-1:0] tx_cnt_q;
        logic [TXW-1:0] tx_cnt_inc;
        logic [3:0]     rx_cnt_q;
        logic [3:0]     rx_cnt_inc;
        logic [TMW-1:0] tmr_q;
        logic [QW-1:0]  wait_q;
        logic           phy_q;
        logic [2:0]     rxs_q;
        logic [7:0]     txd_q;
        logic           txk_q;
        logic           eidle_q;
        logic           is_ts2;
        logic           rx_hit;
        logic           set_done;

        always_comb begin
            is_ts2     = (st_q == POLLING_CONFIG);
            rx_hit     = is_ts2 ? rx_ts2_det[k] : (rx_ts1_det[k] | rx_ts2_det[k]);
            rx_cnt_inc = (rx_hit && (rx_cnt_q < RX_SAT)) ? rx_cnt_q + 4'd1 : rx_cnt_q;
            tx_cnt_inc = (tx_cnt_q < TX_SAT) ? tx_cnt_q + TXW'(1) : tx_cnt_q;
            set_done   = (rx_cnt_q >= RX_SAT) &&
                         (tx_cnt_q >= (is_ts2 ? TS2_LAST : TS1_LAST));
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                st_q     <= DETECT_QUIET;
                idx_q    <= '0;
                tx_cnt_q <= '0;
                rx_cnt_q <= '0;
                tmr_q    <= '0;
                wait_q   <= '0;
                phy_q    <= 1'b0;
                rxs_q    <= 3'd0;
                txd_q    <= 8'h00;
                txk_q    <= 1'b0;
                eidle_q  <= 1'b1;
            end else begin
                phy_q <= 1'b0;
                rxs_q <= 3'd0;
                case (st_q)
                    DETECT_QUIET: begin
                        idx_q    <= '0;
                        tx_cnt_q <= '0;
                        rx_cnt_q <= '0;
                        txd_q    <= 8'h00;
                        txk_q    <= 1'b0;
                        eidle_q  <= 1'b1;
                        if (txdetectrx[k]) begin
                            phy_q <= 1'b1;
                            rxs_q <= 3'd3;
                            st_q  <= DETECT_ACTIVE;
                        end
                    end
                    DETECT_ACTIVE: begin
                        if (powerdown[3*k +: 3] == 3'd0) begin
                            phy_q  <= 1'b1;
                            wait_q <= WAIT_LOAD;
                            st_q   <= POLLING_WAIT;
                        end
                    end
                    POLLING_WAIT: begin
                        if (wait_q == '0) begin
                            st_q           <= POLLING_ACTIVE;
                            tmr_q          <= TMR_LOAD;
                            idx_q          <= '0;
                            tx_cnt_q       <= '0;
                            rx_cnt_q       <= '0;
                            {txk_q, txd_q} <= ts_symbol(4'd0, 1'b0);
                            eidle_q        <= 1'b0;
                        end else begin
                            wait_q <= wait_q - QW'(1);
                        end
                    end
                    POLLING_ACTIVE, POLLING_CONFIG: begin
                        // Timeout wins over any advance decided in the same cycle.
                        if (tmr_q == '0) begin
                            st_q     <= DETECT_QUIET;
                            idx_q    <= '0;
                            tx_cnt_q <= '0;
                            rx_cnt_q <= '0;
                            txd_q    <= 8'h00;
                            txk_q    <= 1'b0;
                            eidle_q  <= 1'b1;
                        end else begin
                            tmr_q <= tmr_q - TMW'(1);
                            if (idx_q == 4'd15) begin
                                idx_q <= '0;
                                if (set_done) begin
                                    tx_cnt_q <= '0;
                                    rx_cnt_q <= '0;
                                    if (is_ts2) begin
                                        st_q           <= L0;
                                        {txk_q, txd_q} <= 9'h000;
                                    end else begin
                                        st_q           <= POLLING_CONFIG;
                                        {txk_q, txd_q} <= ts_symbol(4'd0, 1'b1);
                                    end
                                end else begin
                                    tx_cnt_q       <= tx_cnt_inc;
                                    rx_cnt_q       <= rx_cnt_inc;
                                    {txk_q, txd_q} <= ts_symbol(4'd0, is_ts2);
                                end
                            end else begin
                                idx_q          <= idx_q + 4'd1;
                                rx_cnt_q       <= rx_cnt_inc;
                                {txk_q, txd_q} <= ts_symbol(idx_q + 4'd1, is_ts2);
                            end
                        end
                    end
                    L0: begin
                        txd_q   <= 8'h00;
                        txk_q   <= 1'b0;
                        eidle_q <= 1'b0;
                    end
                    default: begin
                        st_q    <= DETECT_QUIET;
                        eidle_q <= 1'b1;
                    end
                endcase
            end
        end

        assign phystatus[k]          = phy_q;
        assign rxstatus[3*k +: 3]    = rxs_q;
        assign tx_data[8*k +: 8]     = txd_q;
        assign tx_datak[k]           = txk_q;
        assign tx_elecidle[k]        = eidle_q;
        assign lane_state[3*k +: 3]  = st_q;
        assign in_l0[k]              = (st_q == L0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            link_up <= 1'b0;
        end else begin
            link_up <= &in_l0;
        end
    end

endmodule

// File: tb/tb_ozphy_polling_ctrl.sv
// Directed bench for ozphy_polling_ctrl: lane-0 symbol stream is checked by a
// queue-based scoreboard monitor; state/status milestones are checked inline.
module tb_ozphy_polling_ctrl;

    localparam int NL   = 4;
    localparam int NTSP = 4;
    localparam int QC   = 4;
    localparam int TMO  = 400;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NL-1:0]     txdetectrx = '1;
    logic [3*NL-1:0]   powerdown = {NL{3'd2}};
    logic [NL-1:0]     rx_ts1_det = '0;
    logic [NL-1:0]     rx_ts2_det = '0;
    logic [NL-1:0]     phystatus;
    logic [3*NL-1:0]   rxstatus;
    logic [8*NL-1:0]   tx_data;
    logic [NL-1:0]     tx_datak;
    logic [NL-1:0]     tx_elecidle;
    logic [3*NL-1:0]   lane_state;
    logic              link_up;

    ozphy_polling_ctrl #(
        .N_LANES(NL), .NTS(NTSP), .QUIET_CYC(QC), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .txdetectrx(txdetectrx), .powerdown(powerdown),
        .rx_ts1_det(rx_ts1_det), .rx_ts2_det(rx_ts2_det), .phystatus(phystatus),
        .rxstatus(rxstatus), .tx_data(tx_data), .tx_datak(tx_datak),
        .tx_elecidle(tx_elecidle), .lane_state(lane_state), .link_up(link_up)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic [8:0] sym;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected lane-0 symbols: n sets of TS1 or TS2 seen in lane state st.
    task automatic push_sets(input int n, input bit ts2, input logic [2:0] st);
        logic [8:0] tbl [16];
        for (int i = 0; i < 16; i++) tbl[i] = ts2 ? 9'h045 : 9'h04A;
        tbl[0] = 9'h1BC; tbl[1] = 9'h1F7; tbl[2] = 9'h1F7;
        tbl[3] = 9'h000; tbl[4] = 9'h002; tbl[5] = 9'h000;
        for (int s = 0; s < n; s++)
            for (int i = 0; i < 16; i++) exp_q.push_back({st, tbl[i]});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        txdetectrx = '0;
        powerdown = {NL{3'd2}};
        rx_ts1_det = '0;
        rx_ts2_det = '0;
        mon_en = 1'b0;
        exp_q.delete();
        repeat (3) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic start_lanes(input logic [NL-1:0] mask);
        for (int k = 0; k < NL; k++)
            if (mask[k]) powerdown[3*k +: 3] = 3'd0;
        txdetectrx = mask;
        tick();
        txdetectrx = '0;
    endtask

    task automatic wait_state(input int lane, input logic [2:0] st, input int maxc);
        int n = 0;
        while (lane_state[3*lane +: 3] != st && n < maxc) begin
            tick();
            n++;
        end
        chk("wait_state", 32'(lane_state[3*lane +: 3]), 32'(st));
    endtask

    // Scoreboard monitor: every transmitted lane-0 symbol consumes one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && (lane_state[2:0] == 3'd3 || lane_state[2:0] == 3'd4)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sym_extra actual=%0h required=none t=%0t",
                             {lane_state[2:0], tx_datak[0], tx_data[7:0]}, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("sym", {19'd0, tx_elecidle[0], lane_state[2:0], tx_datak[0], tx_data[7:0]},
                        {19'd0, 1'b0, e.st, e.sym});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit eid_ok;

        // Reset with detect requested: everything must stay quiet.
        repeat (3) tick();
        chk("rst_state", 32'(lane_state), 32'd0);
        chk("rst_phy", 32'(phystatus), 32'd0);
        chk("rst_rxstatus", 32'(rxstatus), 32'd0);
        chk("rst_txdata", 32'(tx_data), 32'd0);
        chk("rst_txdatak", 32'(tx_datak), 32'd0);
        chk("rst_eidle", 32'(tx_elecidle), 32'hF);
        chk("rst_linkup", 32'(link_up), 32'd0);
        txdetectrx = '0;
        reset = 1'b0;
        tick();
        chk("idle_state", 32'(lane_state), 32'd0);

        // Receiver detect on lane 0 with lane held in P2.
        txdetectrx = 4'b0001;
        tick();
        txdetectrx = '0;
        chk("det_phy", 32'(phystatus[0]), 32'd1);
        chk("det_rxstatus", 32'(rxstatus[2:0]), 32'd3);
        chk("det_state", 32'(lane_state[2:0]), 32'd1);
        chk("det_lane1_quiet", 32'(lane_state[5:3]), 32'd0);
        tick();
        chk("det_phy_drop", 32'(phystatus[0]), 32'd0);
        chk("det_rxstatus_drop", 32'(rxstatus[2:0]), 32'd0);
        tick();
        chk("det_hold_p2", 32'(lane_state[2:0]), 32'd1);

        // Enter P0, then full training of lane 0 with NTS=4.
        push_sets(4, 1'b0, 3'd3);
        push_sets(16, 1'b1, 3'd4);
        mon_en = 1'b1;
        powerdown[2:0] = 3'd0;
        tick();
        chk("p0_phy", 32'(phystatus[0]), 32'd1);
        chk("p0_state", 32'(lane_state[2:0]), 32'd2);
        n = 0;
        eid_ok = 1'b1;
        while (lane_state[2:0] == 3'd2 && n < 20) begin
            if (!tx_elecidle[0]) eid_ok = 1'b0;
            n++;
            tick();
        end
        chk("wait_cycles", 32'(n), 32'(QC));
        chk("wait_eidle", 32'(eid_ok), 32'd1);
        chk("pa_entry", 32'(lane_state[2:0]), 32'd3);
        for (int c = 0; c < 320; c++) begin
            rx_ts1_det[0] = (c < 8);
            rx_ts2_det[0] = (c >= 64 && c < 72);
            tick();
        end
        rx_ts1_det = '0;
        rx_ts2_det = '0;
        mon_en = 1'b0;
        chk("l0_state", 32'(lane_state[2:0]), 32'd5);
        chk("l0_txdata", 32'({tx_datak[0], tx_data[7:0]}), 32'd0);
        chk("l0_eidle", 32'(tx_elecidle[0]), 32'd0);
        chk("l0_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("l0_linkup_partial", 32'(link_up), 32'd0);

        // No rx pulses: TS1 continues past NTS sets, then timeout.
        do_reset();
        start_lanes(4'b0001);
        wait_state(0, 3'd3, 20);
        n = 0;
        while (lane_state[2:0] == 3'd3 && n < 1000) begin
            if (n == 64) chk("ts1_past_nts_com", 32'({tx_datak[0], tx_data[7:0]}), 32'h1BC);
            if (n == 70) chk("ts1_past_nts_id", 32'({tx_datak[0], tx_data[7:0]}), 32'h04A);
            n++;
            tick();
        end
        chk("timeout_cycles", 32'(n), 32'(TMO));
        chk("timeout_state", 32'(lane_state[2:0]), 32'd0);
        chk("timeout_eidle", 32'(tx_elecidle[0]), 32'd1);
        chk("timeout_txdata", 32'({tx_datak[0], tx_data[7:0]}), 32'd0);

        // Simultaneous TS1+TS2 pulses count once: lane 0 x8 advances, lane 1 x4 does not.
        do_reset();
        push_sets(4, 1'b0, 3'd3);
        push_sets(1, 1'b1, 3'd4);
        mon_en = 1'b1;
        start_lanes(4'b0011);
        wait_state(0, 3'd3, 20);
        for (int c = 0; c < 80; c++) begin
            if (c == 64) chk("dual_x4_no_advance", 32'(lane_state[5:3]), 32'd3);
            rx_ts1_det[1:0] = {c < 4, c < 8};
            rx_ts2_det[1:0] = {c < 4, c < 8};
            tick();
        end
        rx_ts1_det = '0;
        rx_ts2_det = '0;
        mon_en = 1'b0;
        chk("dual_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("dual_lane0_config", 32'(lane_state[2:0]), 32'd4);

        // All lanes train; lane 3 one set late. link_up follows lane 3 by one cycle.
        do_reset();
        start_lanes(4'b1111);
        wait_state(0, 3'd3, 20);
        for (int c = 0; c < 340; c++) begin
            if (c == 320) begin
                chk("all_l0_lane0", 32'(lane_state[2:0]), 32'd5);
                chk("all_l0_lane1", 32'(lane_state[5:3]), 32'd5);
                chk("all_l0_lane2", 32'(lane_state[8:6]), 32'd5);
                chk("late_lane3_config", 32'(lane_state[11:9]), 32'd4);
                chk("linkup_early", 32'(link_up), 32'd0);
            end
            if (c == 336) begin
                chk("late_lane3_l0", 32'(lane_state[11:9]), 32'd5);
                chk("linkup_same_cycle", 32'(link_up), 32'd0);
            end
            if (c == 337) chk("linkup_next_cycle", 32'(link_up), 32'd1);
            rx_ts1_det = {(c >= 64 && c < 72), c < 8, c < 8, c < 8};
            rx_ts2_det = {(c >= 80 && c < 88), {3{(c >= 64 && c < 72)}}};
            tick();
        end
        rx_ts1_det = '0;
        rx_ts2_det = '0;
        chk("linkup_hold", 32'(link_up), 32'd1);

        // Reset in the middle of a TS1 set.
        do_reset();
        start_lanes(4'b0001);
        wait_state(0, 3'd3, 20);
        repeat (7) tick();
        chk("midset_idx7", 32'({tx_datak[0], tx_data[7:0]}), 32'h04A);
        reset = 1'b1;
        #1;
        chk("midset_rst_eidle", 32'(tx_elecidle[0]), 32'd1);
        chk("midset_rst_state", 32'(lane_state[2:0]), 32'd0);
        chk("midset_rst_txdata", 32'({tx_datak[0], tx_data[7:0]}), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("midset_after_rst", 32'(lane_state[2:0]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ozphy_polling_ctrl.md
OZPHY_POLLING_CTRL -- requirements
Module: ozphy_polling_ctrl

Interface
REQ-001 SHALL have parameter N_LANES, default 16: number of independent lane state machines.
REQ-002 SHALL have parameter NTS, default 1024: TS1 ordered sets transmitted before leaving Polling.Active.
REQ-003 SHALL have parameter QUIET_CYC, default 4: clk cycles spent in POLLING_WAIT.
REQ-004 SHALL have parameter TIMEOUT, default 24000: clk cycles allowed in POLLING_ACTIVE or POLLING_CONFIG.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port txdetectrx, input, N_LANES: per-lane receiver-detect request.
REQ-008 SHALL have port powerdown, input, 3*N_LANES: per-lane power state, lane k at [3k+2:3k]; 0 = P0.
REQ-009 SHALL have port rx_ts1_det, input, N_LANES: one-cycle pulse, TS1 received on lane.
REQ-010 SHALL have port rx_ts2_det, input, N_LANES: one-cycle pulse, TS2 received on lane.
REQ-011 SHALL have port phystatus, output, N_LANES: per-lane PIPE phystatus.
REQ-012 SHALL have port rxstatus, output, 3*N_LANES: per-lane PIPE rxstatus.
REQ-013 SHALL have port tx_data, output, 8*N_LANES: per-lane transmit symbol, lane k at [8k+7:8k].
REQ-014 SHALL have port tx_datak, output, N_LANES: per-lane K-symbol flag.
REQ-015 SHALL have port tx_elecidle, output, N_LANES: per-lane transmitter electrical idle.
REQ-016 SHALL have port lane_state, output, 3*N_LANES: per-lane encoded state.
REQ-017 SHALL have port link_up, output, 1: all lanes in L0.

Function
REQ-018 SHALL implement per lane the states DETECT_QUIET=0, DETECT_ACTIVE=1, POLLING_WAIT=2, POLLING_ACTIVE=3, POLLING_CONFIG=4 and L0=5, encoded on lane_state.
REQ-019 SHALL, in DETECT_QUIET with txdetectrx[k]=1, set phystatus=1 and rxstatus=3 for one cycle and go to DETECT_ACTIVE; otherwise phystatus=0 and rxstatus=0.
REQ-020 SHALL, in DETECT_ACTIVE with powerdown=0, pulse phystatus for one cycle and go to POLLING_WAIT; otherwise hold.
REQ-021 SHALL stay in POLLING_WAIT exactly QUIET_CYC cycles with tx_elecidle=1, then go to POLLING_ACTIVE.
REQ-022 SHALL, in POLLING_ACTIVE, drive tx_elecidle=0 and transmit back-to-back 16-symbol TS1 sets from a symbol index 0..15 that wraps to 0.
REQ-023 SHALL use these symbols (data/k): 0 = BC/1 (COM); 1-2 = F7/1 (PAD); 3 = 00/0; 4 = 02/0; 5 = 00/0; 6-15 = 4A/0 for TS1 or 45/0 for TS2.
REQ-024 SHALL count transmitted sets (tx_cnt, incremented at index 15) and received pulses (rx_cnt, rx_ts1_det OR rx_ts2_det), both saturating, with widths sized for NTS and 8.
REQ-025 SHALL go to POLLING_CONFIG only at index 15 when tx_cnt+1>=NTS and rx_cnt>=8, clearing both counters; the next symbol is TS2 index 0.
REQ-026 SHALL, in POLLING_CONFIG, transmit TS2 sets and count only rx_ts2_det, going to L0 at index 15 when TS2 tx_cnt+1>=16 and rx_cnt>=8.
REQ-027 SHALL drive tx_data=00, tx_datak=0, tx_elecidle=0 in L0 and hold L0 until reset.
REQ-028 SHALL reset a per-lane timer on entry to POLLING_ACTIVE and keep it running through POLLING_CONFIG; on reaching TIMEOUT the lane goes to DETECT_QUIET, tx_elecidle=1, counters cleared, and timeout takes priority over a same-cycle advance.
REQ-029 SHALL, when rx_ts1_det and rx_ts2_det pulse in the same cycle, increment rx_cnt by 1.
REQ-030 SHALL drive tx_data=00 and tx_datak=0 outside POLLING_ACTIVE, POLLING_CONFIG and L0.
REQ-031 SHALL drive link_up=1 the cycle after all N_LANES lanes are in L0; otherwise link_up=0.
REQ-032 SHALL keep lanes independent with no cross-lane coupling except link_up.

Reset
REQ-033 SHALL, while reset=1 at any time, put every lane in DETECT_QUIET with phystatus=0, rxstatus=0, tx_data=00, tx_datak=0, tx_elecidle=1, all counters 0, symbol index 0 and link_up=0.
REQ-034 SHALL, on reset asserted mid-ordered-set, abort the set immediately with no partial-symbol completion.

Verification
REQ-035 SHALL cover: txdetectrx[0]=1 one cycle -> the next cycle phystatus[0]=1, rxstatus[2:0]=3, lane_state[2:0]=1, then phystatus[0]=0.
REQ-036 SHALL cover: NTS=4, 8 rx_ts1_det pulses during the first set -> exactly 64 TS1 symbols (BC,F7,F7,00,02,00,4Ax10 each), then TS2 starting with BC.
REQ-037 SHALL cover: NTS=4, no rx pulses -> TS1 continues past 4 sets and the lane returns to DETECT_QUIET after exactly TIMEOUT cycles with tx_elecidle=1.
REQ-038 SHALL cover: all lanes complete training, lane 3 one set late -> link_up=1 only one cycle after lane 3 reaches L0.
REQ-039 SHALL cover: reset pulsed while lane 0 is at TS1 index 7 -> immediately tx_elecidle=1, lane_state=0, tx_data=00.
REQ-040 SHALL cover: simultaneous rx_ts1_det and rx_ts2_det pulses x8 in POLLING_ACTIVE -> rx_cnt=8, and transition at the next eligible index 15.
